// File: rtl/udp_submsg_extract.sv
// Picks the sub-message addressed to this node's hop_count out of the chain stream and
// publishes its payload through a ping-pong buffer. Optional macro: UDP_SUBMSG_BROADCAST_EN.
module udp_submsg_extract #(
    parameter int AW        = 6,
    parameter int BUF_DEPTH = 64
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic [15:0]   hop_count,
    input  logic [7:0]    rxd,
    input  logic          rxdv,
    input  logic          rxlast,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [15:0]   msg_len,
    output logic          msg_valid,
    output logic [7:0]    msg_seq,
    output logic [7:0]    err_cnt
);

    localparam logic [15:0] DEPTH16 = 16'(BUF_DEPTH);

    typedef enum logic [2:0] {S_ALO, S_AHI, S_LLO, S_LHI, S_PAY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        match_q, match_d;
    logic        found_q, found_d;
    logic        ovf_q, ovf_d;
    logic [15:0] found_len_q, found_len_d;
    logic        pub_bank_q, pub_bank_d;
    logic        has_content_q, has_content_d;
    logic [15:0] msg_len_q, msg_len_d;
    logic        msg_valid_q, msg_valid_d;
    logic [7:0]  msg_seq_q, msg_seq_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        rd_gate_q;

    logic        addr_hit;
    logic        wr_en;
    logic [AW:0] wr_addr;
    logic        publish;
    logic        discard;

    logic [7:0]  mem_q [0:2*BUF_DEPTH-1];
    logic [7:0]  mem_rd_q;

`ifdef UDP_SUBMSG_BROADCAST_EN
    assign addr_hit = ({rxd, addr_lo_q} == hop_count) || ({rxd, addr_lo_q} == 16'hFFFF);
`else
    assign addr_hit = ({rxd, addr_lo_q} == hop_count);
`endif

    assign wr_addr = {~pub_bank_q, cnt_q[AW-1:0]};

    always_comb begin
        state_d       = state_q;
        addr_lo_d     = addr_lo_q;
        len_lo_d      = len_lo_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        match_d       = match_q;
        found_d       = found_q;
        ovf_d         = ovf_q;
        found_len_d   = found_len_q;
        pub_bank_d    = pub_bank_q;
        has_content_d = has_content_q;
        msg_len_d     = msg_len_q;
        msg_valid_d   = 1'b0;
        msg_seq_d     = msg_seq_q;
        err_cnt_d     = err_cnt_q;
        wr_en         = 1'b0;
        publish       = 1'b0;
        discard       = 1'b0;

        if (rxdv) begin
            case (state_q)
                S_ALO: begin
                    addr_lo_d = rxd;
                    state_d   = S_AHI;
                end
                S_AHI: begin
                    match_d = addr_hit && !found_q;
                    state_d = S_LLO;
                end
                S_LLO: begin
                    len_lo_d = rxd;
                    state_d  = S_LHI;
                end
                S_LHI: begin
                    len_d = {rxd, len_lo_q};
                    if ({rxd, len_lo_q} == 16'd0) begin
                        state_d = S_ALO;
                        if (match_q) begin
                            found_d     = 1'b1;
                            found_len_d = 16'd0;
                        end
                    end else begin
                        state_d = S_PAY;
                        cnt_d   = 16'd0;
                    end
                end
                S_PAY: begin
                    cnt_d = cnt_q + 16'd1;
                    if (match_q) begin
                        if (cnt_q >= DEPTH16) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                    // len_q is never 0 here, so len_q-1 cannot wrap
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = S_ALO;
                        if (match_q) begin
                            found_d     = 1'b1;
                            found_len_d = len_q;
                        end
                    end
                end
                default: state_d = S_ALO;
            endcase
        end

        // End of packet is judged on the post-byte flags so a coincident byte counts.
        if (rxlast) begin
            publish = found_d && !ovf_d;
            discard = ovf_d || (match_d && !found_d);
            if (publish) begin
                pub_bank_d    = ~pub_bank_q;
                has_content_d = 1'b1;
                msg_len_d     = found_len_d;
                msg_seq_d     = msg_seq_q + 8'd1;
                msg_valid_d   = 1'b1;
            end else if (discard && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = S_ALO;
            match_d = 1'b0;
            found_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ALO;
            addr_lo_q     <= 8'd0;
            len_lo_q      <= 8'd0;
            len_q         <= 16'd0;
            cnt_q         <= 16'd0;
            match_q       <= 1'b0;
            found_q       <= 1'b0;
            ovf_q         <= 1'b0;
            found_len_q   <= 16'd0;
            pub_bank_q    <= 1'b0;
            has_content_q <= 1'b0;
            msg_len_q     <= 16'd0;
            msg_valid_q   <= 1'b0;
            msg_seq_q     <= 8'd0;
            err_cnt_q     <= 8'd0;
            rd_gate_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_lo_q     <= addr_lo_d;
            len_lo_q      <= len_lo_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            match_q       <= match_d;
            found_q       <= found_d;
            ovf_q         <= ovf_d;
            found_len_q   <= found_len_d;
            pub_bank_q    <= pub_bank_d;
            has_content_q <= has_content_d;
            msg_len_q     <= msg_len_d;
            msg_valid_q   <= msg_valid_d;
            msg_seq_q     <= msg_seq_d;
            err_cnt_q     <= err_cnt_d;
            // Lags has_content_q by one cycle to line up with the registered RAM read
            rd_gate_q     <= has_content_q;
        end
    end

    // Buffer RAM: no reset so it maps onto block RAM; the write bank is never the read bank.
    always_ff @(posedge c) begin
        if (wr_en) begin
            mem_q[wr_addr] <= rxd;
        end
        mem_rd_q <= mem_q[{pub_bank_q, rd_addr}];
    end

    assign rd_data   = rd_gate_q ? mem_rd_q : 8'h00;
    assign msg_len   = msg_len_q;
    assign msg_valid = msg_valid_q;
    assign msg_seq   = msg_seq_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_udp_submsg_extract.sv
// Randomised and directed bench for udp_submsg_extract; a packet-level parser model
// predicts publish/discard outcomes and the published payload.
module tb_udp_submsg_extract;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef UDP_SUBMSG_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic          c = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   hop_count = 16'd0;
    logic [7:0]    rxd = 8'd0;
    logic          rxdv = 1'b0;
    logic          rxlast = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [15:0]   msg_len;
    logic          msg_valid;
    logic [7:0]    msg_seq;
    logic [7:0]    err_cnt;

    udp_submsg_extract #(.AW(AW), .BUF_DEPTH(DEPTH)) dut (
        .c(c), .rst_n(rst_n), .hop_count(hop_count), .rxd(rxd), .rxdv(rxdv),
        .rxlast(rxlast), .rd_addr(rd_addr), .rd_data(rd_data), .msg_len(msg_len),
        .msg_valid(msg_valid), .msg_seq(msg_seq), .err_cnt(err_cnt)
    );

    always #5 c = ~c;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    logic [7:0] exp_mem[DEPTH];
    int         exp_len = 0;
    int         exp_seq = 0;
    int         exp_err = 0;
    bit         exp_has = 1'b0;
    bit         exp_pub = 1'b0;
    logic       obs_valid;
    logic       obs_after;
    logic [7:0] obs_mem[DEPTH];

    // Parse the whole packet as a list of sub-messages and decide its fate.
    task automatic model_packet(input logic [15:0] hop);
        int i = 0;
        logic [15:0] addr;
        int len;
        bit hit;
        exp_pub = 1'b0;
        while (i + 2 <= pkt.size()) begin
            addr = {pkt[i+1], pkt[i]};
            hit  = (addr == hop) || (BCAST && addr == 16'hFFFF);
            if (i + 4 > pkt.size()) begin
                if (hit && exp_err < 255) exp_err++;
                break;
            end
            len = int'({pkt[i+3], pkt[i+2]});
            if (i + 4 + len > pkt.size()) begin
                if (hit && exp_err < 255) exp_err++;
                break;
            end
            if (hit) begin
                if (len > DEPTH) begin
                    if (exp_err < 255) exp_err++;
                end else begin
                    exp_pub = 1'b1;
                    exp_seq = (exp_seq + 1) % 256;
                    exp_len = len;
                    exp_has = 1'b1;
                    for (int k = 0; k < len; k++) exp_mem[k] = pkt[i+4+k];
                end
                break;
            end
            i += 4 + len;
        end
    endtask

    task automatic send_packet(input int min_gap, input int max_gap, input bit coincide);
        for (int idx = 0; idx < pkt.size(); idx++) begin
            repeat ($urandom_range(max_gap, min_gap)) begin
                rxdv = 1'b0; rxlast = 1'b0;
                @(posedge c); #1;
            end
            rxd    = pkt[idx];
            rxdv   = 1'b1;
            rxlast = coincide && (idx == pkt.size() - 1);
            @(posedge c); #1;
        end
        rxdv = 1'b0;
        if (!coincide || pkt.size() == 0) begin
            rxlast = 1'b1;
            @(posedge c); #1;
        end
        rxlast    = 1'b0;
        obs_valid = msg_valid;
        @(posedge c); #1;
        obs_after = msg_valid;
    endtask

    task automatic readback();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(posedge c); #1;
            obs_mem[a] = rd_data;
        end
    endtask

    task automatic run_packet(input logic [15:0] hop, input int min_gap, input int max_gap,
                              input bit coincide);
        hop_count = hop;
        model_packet(hop);
        send_packet(min_gap, max_gap, coincide);
        readback();
    endtask

    task automatic load_test1();
        pkt = {8'h00, 8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h01, 8'h00, 8'h02, 8'h00,
               8'h56, 8'h78, 8'h02, 8'h00, 8'h04, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h42};
    endtask

    task automatic test_reset();
        repeat (3) @(posedge c);
        #1;
        if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", msg_valid); end
        checks++;
        if (msg_seq !== 8'd0) begin errors++; $display("FAIL reset_seq got %0d exp 0", msg_seq); end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
        checks++;
        if (msg_len !== 16'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", msg_len); end
        checks++;
        rst_n = 1'b1;
        rd_addr = '0;
        repeat (2) @(posedge c);
        #1;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        load_test1();
        run_packet(16'd1, 0, 0, 1'b0);
        if (obs_valid !== 1'b1 || obs_after !== 1'b0) begin
            errors++; $display("FAIL basic_pulse got %0b%0b exp 10", obs_valid, obs_after);
        end
        checks++;
        if (msg_len !== 16'd2) begin errors++; $display("FAIL basic_len got %0d exp 2", msg_len); end
        checks++;
        if (msg_seq !== 8'd1) begin errors++; $display("FAIL basic_seq got %0d exp 1", msg_seq); end
        checks++;
        if (obs_mem[0] !== 8'h56 || obs_mem[1] !== 8'h78) begin
            errors++; $display("FAIL basic_data got %h %h exp 56 78", obs_mem[0], obs_mem[1]);
        end
        checks++;
        $display("test_basic: len=%0d seq=%0d data=%h %h", msg_len, msg_seq, obs_mem[0], obs_mem[1]);
    endtask

    task automatic test_no_match();
        load_test1();
        run_packet(16'd5, 0, 0, 1'b0);
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL nomatch_valid got %0b exp 0", obs_valid); end
        checks++;
        if (msg_seq !== 8'(exp_seq) || err_cnt !== 8'(exp_err)) begin
            errors++; $display("FAIL nomatch_cnt got seq %0d err %0d exp %0d %0d", msg_seq, err_cnt, exp_seq, exp_err);
        end
        checks++;
        if (obs_mem[0] !== 8'h56 || obs_mem[1] !== 8'h78) begin
            errors++; $display("FAIL nomatch_data got %h %h exp 56 78", obs_mem[0], obs_mem[1]);
        end
        checks++;
        $display("test_no_match: seq=%0d err=%0d", msg_seq, err_cnt);
    endtask

    task automatic test_truncate();
        load_test1();
        pkt.pop_back(); pkt.pop_back();
        run_packet(16'd2, 0, 0, 1'b1);
        if (obs_valid !== 1'b0 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL trunc_err got valid %0b err %0d exp 0 1", obs_valid, err_cnt);
        end
        checks++;
        load_test1();
        run_packet(16'd2, 0, 0, 1'b0);
        if (obs_valid !== 1'b1 || msg_len !== 16'd4) begin
            errors++; $display("FAIL trunc_next got valid %0b len %0d exp 1 4", obs_valid, msg_len);
        end
        checks++;
        if ({obs_mem[0], obs_mem[1], obs_mem[2], obs_mem[3]} !== 32'hABCDEF42) begin
            errors++; $display("FAIL trunc_data got %h%h%h%h exp abcdef42", obs_mem[0], obs_mem[1], obs_mem[2], obs_mem[3]);
        end
        checks++;
        $display("test_truncate: err=%0d len=%0d seq=%0d", err_cnt, msg_len, msg_seq);
    endtask

    task automatic test_overflow();
        int e0;
        e0 = exp_err;
        pkt = {8'h07, 8'h00, 8'h41, 8'h00};
        for (int k = 0; k < 65; k++) pkt.push_back(8'($urandom));
        run_packet(16'd7, 0, 0, 1'b1);
        if (obs_valid !== 1'b0 || err_cnt !== 8'(e0 + 1)) begin
            errors++; $display("FAIL ovf_err got valid %0b err %0d exp 0 %0d", obs_valid, err_cnt, e0 + 1);
        end
        checks++;
        pkt = {8'h07, 8'h00, 8'h40, 8'h00};
        for (int k = 0; k < 64; k++) pkt.push_back(8'($urandom));
        run_packet(16'd7, 0, 0, 1'b0);
        if (obs_valid !== 1'b1 || msg_len !== 16'd64) begin
            errors++; $display("FAIL ovf_next got valid %0b len %0d exp 1 64", obs_valid, msg_len);
        end
        checks++;
        for (int a = 0; a < DEPTH; a++) begin
            if (obs_mem[a] !== pkt[4+a]) begin
                errors++; $display("FAIL ovf_data[%0d] got %h exp %h", a, obs_mem[a], pkt[4+a]);
            end
            checks++;
        end
        $display("test_overflow: err=%0d len=%0d", err_cnt, msg_len);
    endtask

    task automatic test_gaps();
        int s0;
        s0 = exp_seq;
        load_test1();
        run_packet(16'd1, 1, 3, 1'b1);
        if (obs_valid !== 1'b1 || msg_len !== 16'd2 || msg_seq !== 8'(s0 + 1)) begin
            errors++; $display("FAIL gaps_pub got valid %0b len %0d seq %0d exp 1 2 %0d", obs_valid, msg_len, msg_seq, s0 + 1);
        end
        checks++;
        if (obs_mem[0] !== 8'h56 || obs_mem[1] !== 8'h78) begin
            errors++; $display("FAIL gaps_data got %h %h exp 56 78", obs_mem[0], obs_mem[1]);
        end
        checks++;
        $display("test_gaps: len=%0d seq=%0d", msg_len, msg_seq);
    endtask

    task automatic test_reset_mid();
        load_test1();
        hop_count = 16'd2;
        for (int idx = 0; idx < 18; idx++) begin
            rxd = pkt[idx]; rxdv = 1'b1;
            @(posedge c); #1;
        end
        rst_n = 1'b0;
        #1;
        if ({msg_valid, msg_seq, err_cnt, msg_len, rd_data} !== 41'd0) begin
            errors++; $display("FAIL rstmid_outputs got v%0b s%0d e%0d l%0d d%h exp all 0", msg_valid, msg_seq, err_cnt, msg_len, rd_data);
        end
        checks++;
        rxdv = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge c); #1;
        exp_seq = 0; exp_err = 0; exp_len = 0; exp_has = 1'b0;
        load_test1();
        run_packet(16'd1, 0, 0, 1'b0);
        if (obs_valid !== 1'b1 || msg_seq !== 8'd1 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL rstmid_next got valid %0b seq %0d err %0d exp 1 1 0", obs_valid, msg_seq, err_cnt);
        end
        checks++;
        pkt = {8'hFF, 8'hFF, 8'h01, 8'h00, 8'h99};
        run_packet(16'd3, 0, 0, 1'b0);
        if (obs_valid !== exp_pub || msg_len !== 16'(exp_len)) begin
            errors++; $display("FAIL bcast got valid %0b len %0d exp %0b %0d", obs_valid, msg_len, exp_pub, exp_len);
        end
        checks++;
        if (obs_mem[0] !== exp_mem[0]) begin
            errors++; $display("FAIL bcast_data got %h exp %h", obs_mem[0], exp_mem[0]);
        end
        checks++;
        $display("test_reset_mid: seq=%0d len=%0d d0=%h", msg_seq, msg_len, obs_mem[0]);
    endtask

    task automatic test_random();
        logic [15:0] hop, addr;
        int nsub, len, cut;
        logic [7:0] exp_b;
        for (int p = 0; p < 30; p++) begin
            hop = 16'($urandom_range(9, 0));
            pkt = {};
            nsub = $urandom_range(4, 1);
            for (int s = 0; s < nsub; s++) begin
                case ($urandom % 4)
                    0, 1:    addr = hop;
                    2:       addr = 16'($urandom_range(9, 0));
                    default: addr = 16'hFFFF;
                endcase
                case ($urandom % 8)
                    0:       len = 0;
                    1:       len = 64;
                    2:       len = 65;
                    default: len = $urandom_range(20, 1);
                endcase
                pkt.push_back(addr[7:0]); pkt.push_back(addr[15:8]);
                pkt.push_back(8'(len));   pkt.push_back(8'(len >> 8));
                for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
            end
            if ($urandom % 4 == 0) begin
                cut = $urandom_range(pkt.size() - 1, 1);
                while (pkt.size() > cut) pkt.pop_back();
            end
            run_packet(hop, 0, $urandom_range(2, 0), 1'($urandom % 2));
            if (obs_valid !== exp_pub || obs_after !== 1'b0) begin
                errors++; $display("FAIL rand%0d_valid got %0b%0b exp %0b0", p, obs_valid, obs_after, exp_pub);
            end
            checks++;
            if (msg_seq !== 8'(exp_seq) || err_cnt !== 8'(exp_err) || msg_len !== 16'(exp_len)) begin
                errors++; $display("FAIL rand%0d_regs got seq %0d err %0d len %0d exp %0d %0d %0d",
                                   p, msg_seq, err_cnt, msg_len, exp_seq, exp_err, exp_len);
            end
            checks++;
            for (int a = 0; a < DEPTH; a++) begin
                if ((exp_has && a < exp_len) || (!exp_has && a == 0)) begin
                    exp_b = exp_has ? exp_mem[a] : 8'h00;
                    if (obs_mem[a] !== exp_b) begin
                        errors++; $display("FAIL rand%0d_data[%0d] got %h exp %h", p, a, obs_mem[a], exp_b);
                    end
                    checks++;
                end
            end
            $display("test_random pkt %0d: hop=%0d bytes=%0d pub=%0b seq=%0d err=%0d len=%0d",
                     p, hop, pkt.size(), exp_pub, msg_seq, err_cnt, msg_len);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_match();
        test_truncate();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
